// File: rtl/drink_pkg.sv
// Shared state encoding and coin helpers for the drink vending controller.
// Exports: state_t (IDLE/COLLECT/VEND/CHANGE), STATE_W, coin_value(i).
package drink_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    CHANGE  = 2'b11
  } state_t;

  function automatic int unsigned coin_value(input int unsigned i);
    return 32'd1 << i;
  endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Two-flop coin sampler with registered rising-edge vector and multi-hot flag.
// Ports: clk, rst_n, x[N-1:0] in; rise[N-1:0], multi_hot out (one cycle).
module coin_edge_detect #(
  parameter int N_COIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COIN-1:0] x,
  output logic [N_COIN-1:0] rise,
  output logic              multi_hot
);

  logic [N_COIN-1:0] x_q;
  logic [N_COIN-1:0] x_q2;
  logic [N_COIN-1:0] rise_c;

  assign rise_c = x_q & ~x_q2;

  // Edge vector is registered so a coin lands two edges after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      x_q2      <= '0;
      rise      <= '0;
      multi_hot <= 1'b0;
    end else begin
      x_q       <= x;
      x_q2      <= x_q;
      rise      <= rise_c;
      multi_hot <= (rise_c & (rise_c - N_COIN'(1))) != '0;
    end
  end

endmodule

// File: rtl/drink_vendor.sv
// Coin-operated drink vending FSM: credit accumulate, vend, change out.
// Ports: CP_20ms, Rst_async_n, X, Cancel (DRINK_CANCEL_EN) in; cur_state, Z, Credit, Rej out.
module drink_vendor
  import drink_pkg::*;
#(
  parameter int N_COIN   = 2,
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4
) (
  input  logic                CP_20ms,
  input  logic                Rst_async_n,
  input  logic [N_COIN-1:0]   X,
`ifdef DRINK_CANCEL_EN
  input  logic                Cancel,
`endif
  output logic [STATE_W-1:0]  cur_state,
  output logic [1:0]          Z,
  output logic [CREDIT_W-1:0] Credit,
  output logic                Rej
);

  if (PRICE < 1 ||
      PRICE - 1 + (1 << (N_COIN - 1)) >= (1 << CREDIT_W)) begin : g_bad_cfg
    $error("drink_vendor: PRICE/CREDIT_W combination can overflow credit");
  end

  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

  logic [N_COIN-1:0]   rise;
  logic                multi_hot;
  logic                coin;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] remain;
  logic                cancel_hit;
  state_t              state;

  coin_edge_detect #(.N_COIN(N_COIN)) u_edge (
    .clk       (CP_20ms),
    .rst_n     (Rst_async_n),
    .x         (X),
    .rise      (rise),
    .multi_hot (multi_hot)
  );

  always_comb begin
    coin_val = '0;
    for (int i = 0; i < N_COIN; i++) begin
      if (rise[i]) coin_val = coin_val | CREDIT_W'(coin_value(i));
    end
  end

  assign coin   = |rise;
  assign sum    = Credit + coin_val;
  assign remain = Credit - PRICE_W;

`ifdef DRINK_CANCEL_EN
  assign cancel_hit = Cancel && (state == COLLECT) && (Credit != '0);
`else
  assign cancel_hit = 1'b0;
`endif

  always_ff @(posedge CP_20ms or negedge Rst_async_n) begin
    if (!Rst_async_n) begin
      state  <= IDLE;
      Credit <= '0;
      Z      <= 2'b00;
      Rej    <= 1'b0;
    end else begin
      Rej <= 1'b0;
      unique case (state)
        IDLE: begin
          if (multi_hot) begin
            Rej <= 1'b1;
          end else if (coin) begin
            Credit <= coin_val;
            if (coin_val >= PRICE_W) begin
              state <= VEND;
              Z     <= 2'b10;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (cancel_hit) begin
            // Refund the whole credit through the change path.
            Rej   <= coin;
            state <= CHANGE;
            Z     <= 2'b01;
          end else if (multi_hot) begin
            Rej <= 1'b1;
          end else if (coin) begin
            Credit <= sum;
            if (sum >= PRICE_W) begin
              state <= VEND;
              Z     <= 2'b10;
            end
          end
        end
        VEND: begin
          Rej    <= coin;
          Credit <= remain;
          if (remain != '0) begin
            state <= CHANGE;
            Z     <= 2'b01;
          end else begin
            state <= IDLE;
            Z     <= 2'b00;
          end
        end
        CHANGE: begin
          Rej    <= coin;
          Credit <= Credit - 1'b1;
          if (Credit <= CREDIT_W'(1)) begin
            state <= IDLE;
            Z     <= 2'b00;
          end
        end
        default: begin
          state  <= IDLE;
          Credit <= '0;
          Z      <= 2'b00;
        end
      endcase
    end
  end

  assign cur_state = state;

endmodule
